// File: rtl/mac_acc_seq.sv
// mac_acc_seq: job sequencer for the four-lane MAC accumulator.
// Accepts one job (config word + beat count), drives the accumulator
// reset/enable for exactly that many beats, then returns the four lane
// results over a valid/ready handshake.
// Optional feature macro: MAC_ACC_SEQ_PERF_EN (RUN-cycle stall counter on perf_stall).
module mac_acc_seq #(
  parameter int unsigned MAC_CONF_WIDTH = 3,
  parameter int unsigned MAC_MIN_WIDTH  = 8,
  parameter int unsigned MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    job_valid,
  output logic                                    job_ready,
  input  logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] job_cfg,
  input  logic [CNT_WIDTH-1:0]                    job_len,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] acc_cfg,
  output logic                                    acc_rst,
  output logic                                    acc_en,
  input  logic [4*MAC_ACC_WIDTH-1:0]              acc_res,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [4*MAC_ACC_WIDTH-1:0]              res_data,
  output logic                                    busy,
  output logic [CNT_WIDTH-1:0]                    perf_stall
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [CNT_WIDTH-1:0] rem_q;
  logic                 job_take_c;
  logic                 beat_take_c;

  // State register; reset aborts any job straight back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state handshake/accumulator control decode.
  always_comb begin
    state_d     = state_q;
    job_ready   = 1'b0;
    in_ready    = 1'b0;
    acc_en      = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    job_take_c  = 1'b0;
    beat_take_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        job_ready  = 1'b1;
        busy       = 1'b0;
        job_take_c = job_valid;
        if (job_valid) state_d = LOAD;
      end
      LOAD: begin
        state_d = (rem_q == '0) ? SETTLE : RUN;
      end
      RUN: begin
        in_ready    = 1'b1;
        acc_en      = in_valid;
        beat_take_c = in_valid;
        if (in_valid && (rem_q == CNT_WIDTH'(1))) state_d = SETTLE;
      end
      SETTLE: begin
        state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Init-load pulse also fires on every reset cycle so an aborted job leaves a clean accumulator.
  assign acc_rst = rst | (state_q == LOAD);

  // Job capture, beat countdown and result capture at the end of SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cfg  <= '0;
      rem_q    <= '0;
      res_data <= '0;
    end else begin
      if (job_take_c) begin
        acc_cfg <= job_cfg;
        rem_q   <= job_len;
      end
      if (beat_take_c && (rem_q != '0)) begin
        rem_q <= rem_q - CNT_WIDTH'(1);
      end
      if (state_q == SETTLE) begin
        res_data <= acc_res;
      end
    end
  end

`ifdef MAC_ACC_SEQ_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q;

  // Saturating count of RUN cycles with no product beat offered, summed across jobs.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == RUN) && !in_valid && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign perf_stall = stall_q;
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_mac_acc_seq.sv
// tb_mac_acc_seq: directed self-checking bench for mac_acc_seq with a small
// behavioural four-lane accumulator hooked to acc_rst/acc_en/acc_cfg.
module tb_mac_acc_seq;

  localparam int unsigned CW   = 3;
  localparam int unsigned AW   = 32;
  localparam int unsigned CFGW = 4 * AW + CW;
  localparam int unsigned RESW = 4 * AW;
  localparam int unsigned NW   = 16;

  logic            clk;
  logic            rst;
  logic            job_valid;
  logic            job_ready;
  logic [CFGW-1:0] job_cfg;
  logic [NW-1:0]   job_len;
  logic            in_valid;
  logic            in_ready;
  logic [CFGW-1:0] acc_cfg;
  logic            acc_rst;
  logic            acc_en;
  logic [RESW-1:0] acc_res;
  logic            res_valid;
  logic            res_ready;
  logic [RESW-1:0] res_data;
  logic            busy;
  logic [NW-1:0]   perf_stall;

  int tests_run;
  int tests_failed;
  int en_cnt;
  int rdy_cnt;
  int resv_cnt;

  logic [AW-1:0] acc_m [4];
  logic [AW-1:0] prod  [4];

  mac_acc_seq dut (
    .clk        (clk),
    .rst        (rst),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_cfg    (job_cfg),
    .job_len    (job_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .acc_cfg    (acc_cfg),
    .acc_rst    (acc_rst),
    .acc_en     (acc_en),
    .acc_res    (acc_res),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy),
    .perf_stall (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural accumulator: init-load on acc_rst, add (cfg[2]=1) or overwrite (cfg[2]=0) on acc_en.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (acc_rst)     acc_m[i] <= acc_cfg[CW + AW*i +: AW];
      else if (acc_en) acc_m[i] <= acc_cfg[2] ? (acc_m[i] + prod[i]) : prod[i];
    end
  end
  assign acc_res = {acc_m[3], acc_m[2], acc_m[1], acc_m[0]};

  // Cycle counters sampled on the falling edge.
  always @(negedge clk) begin
    if (acc_en)    en_cnt++;
    if (in_ready)  rdy_cnt++;
    if (res_valid) resv_cnt++;
  end

  function automatic logic [CFGW-1:0] mk_cfg(input logic [AW-1:0] i3, input logic [AW-1:0] i2,
                                             input logic [AW-1:0] i1, input logic [AW-1:0] i0,
                                             input logic [CW-1:0] c);
    return {i3, i2, i1, i0, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a job for one cycle; on return the bench is one cycle after acceptance.
  task automatic start_job(input logic [CFGW-1:0] cfg, input logic [NW-1:0] len);
    job_cfg   = cfg;
    job_len   = len;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic clear_counts();
    en_cnt   = 0;
    rdy_cnt  = 0;
    resv_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests_run++;
    if (acc_rst !== 1'b1) begin tests_failed++; $display("FAIL rst_acc_rst: got %0b want 1", acc_rst); end
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if ({job_ready, in_ready, acc_en, res_valid, busy, acc_rst} !== 6'b100000) begin
      tests_failed++; $display("FAIL rst_ctrl: got %b want 100000", {job_ready, in_ready, acc_en, res_valid, busy, acc_rst});
    end
    tests_run++;
    if ((acc_cfg !== '0) || (res_data !== '0)) begin
      tests_failed++; $display("FAIL rst_data: got cfg %0h res %0h want 0", acc_cfg, res_data);
    end
    tests_run++;
    if (perf_stall !== '0) begin tests_failed++; $display("FAIL rst_perf: got %0d want 0", perf_stall); end
  endtask

  task automatic test_accumulate();
    logic [CFGW-1:0] cfg;
    cfg = mk_cfg(32'd0, 32'd0, 32'd0, 32'd0, 3'b100);
    clear_counts();
    start_job(cfg, 16'd4);
    tests_run++;
    if ({acc_rst, busy, job_ready, in_ready} !== 4'b1100) begin
      tests_failed++; $display("FAIL acc_load: got %b want 1100", {acc_rst, busy, job_ready, in_ready});
    end
    tests_run++;
    if (acc_cfg !== cfg) begin tests_failed++; $display("FAIL acc_cfg: got %0h want %0h", acc_cfg, cfg); end
    tick();
    tests_run++;
    if ({in_ready, acc_rst} !== 2'b10) begin tests_failed++; $display("FAIL acc_run: got %b want 10", {in_ready, acc_rst}); end
    in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      prod[0] = AW'(k);
      tick();
    end
    in_valid = 1'b0;
    tests_run++;
    if ({res_valid, in_ready, busy} !== 3'b001) begin
      tests_failed++; $display("FAIL acc_settle: got %b want 001", {res_valid, in_ready, busy});
    end
    tick();
    tests_run++;
    if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL acc_lat: res_valid got %0b want 1", res_valid); end
    tests_run++;
    if (res_data[AW-1:0] !== 32'd10) begin tests_failed++; $display("FAIL acc_sum: got %0d want 10", res_data[AW-1:0]); end
    tests_run++;
    if (en_cnt !== 4) begin tests_failed++; $display("FAIL acc_en_cnt: got %0d want 4", en_cnt); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tests_run++;
    if ({busy, job_ready, res_valid} !== 3'b010) begin
      tests_failed++; $display("FAIL acc_idle: got %b want 010", {busy, job_ready, res_valid});
    end
  endtask

  task automatic test_mult_only();
    clear_counts();
    start_job(mk_cfg(32'd0, 32'd0, 32'd0, 32'd100, 3'b001), 16'd3);
    tick();
    in_valid = 1'b1;
    for (int k = 5; k <= 7; k++) begin
      prod[0] = AW'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if ({res_valid, res_data[AW-1:0]} !== {1'b1, 32'd7}) begin
      tests_failed++; $display("FAIL mult_res: got v=%0b d=%0d want v=1 d=7", res_valid, res_data[AW-1:0]);
    end
    tests_run++;
    if (en_cnt !== 3) begin tests_failed++; $display("FAIL mult_en_cnt: got %0d want 3", en_cnt); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_stalls();
    logic [5:0] pat;
    int         beat;
    pat  = 6'b101001;
    beat = 1;
    clear_counts();
    start_job(mk_cfg(32'd0, 32'd0, 32'd0, 32'd0, 3'b100), 16'd3);
    tick();
    for (int k = 0; k < 6; k++) begin
      in_valid = pat[k];
      prod[0]  = AW'(beat);
      if (pat[k]) beat++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (en_cnt !== 3) begin tests_failed++; $display("FAIL stall_en_cnt: got %0d want 3", en_cnt); end
    tests_run++;
    if (rdy_cnt !== 6) begin tests_failed++; $display("FAIL stall_run_len: got %0d want 6", rdy_cnt); end
    tests_run++;
    if ({res_valid, res_data[AW-1:0]} !== {1'b1, 32'd6}) begin
      tests_failed++; $display("FAIL stall_sum: got v=%0b d=%0d want v=1 d=6", res_valid, res_data[AW-1:0]);
    end
    tests_run++;
`ifdef MAC_ACC_SEQ_PERF_EN
    if (perf_stall !== 16'd3) begin tests_failed++; $display("FAIL stall_perf: got %0d want 3", perf_stall); end
`else
    if (perf_stall !== 16'd0) begin tests_failed++; $display("FAIL stall_perf: got %0d want 0", perf_stall); end
`endif
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_zero_len();
    logic [CFGW-1:0] cfg;
    cfg = mk_cfg(32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, 3'b110);
    clear_counts();
    in_valid = 1'b1;
    start_job(cfg, 16'd0);
    tick();
    tests_run++;
    if ({res_valid, busy, in_ready} !== 3'b010) begin
      tests_failed++; $display("FAIL zero_settle: got %b want 010", {res_valid, busy, in_ready});
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL zero_lat: res_valid got %0b want 1", res_valid); end
    tests_run++;
    if (res_data !== cfg[CFGW-1:CW]) begin
      tests_failed++; $display("FAIL zero_init: got %0h want %0h", res_data, cfg[CFGW-1:CW]);
    end
    tests_run++;
    if (en_cnt !== 0) begin tests_failed++; $display("FAIL zero_en_cnt: got %0d want 0", en_cnt); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [CFGW-1:0] cfg_a;
    logic [CFGW-1:0] cfg_b;
    logic [RESW-1:0] want;
    cfg_a = mk_cfg(32'hA3, 32'hA2, 32'hA1, 32'hA0, 3'b100);
    cfg_b = mk_cfg(32'hB3, 32'hB2, 32'hB1, 32'hB0, 3'b011);
    want  = cfg_a[CFGW-1:CW];
    start_job(cfg_a, 16'd0);
    tick();
    tick();
    job_cfg   = cfg_b;
    job_len   = 16'd0;
    job_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if ({res_valid, job_ready, res_data} !== {1'b1, 1'b0, want}) begin
        tests_failed++; $display("FAIL bp_hold%0d: got v=%0b jr=%0b d=%0h want v=1 jr=0 d=%0h", k, res_valid, job_ready, res_data, want);
      end
      tick();
    end
    tests_run++;
    if (acc_cfg !== cfg_a) begin tests_failed++; $display("FAIL bp_cfg_hold: got %0h want %0h", acc_cfg, cfg_a); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tests_run++;
    if ({busy, job_ready, res_valid} !== 3'b010) begin
      tests_failed++; $display("FAIL bp_idle: got %b want 010", {busy, job_ready, res_valid});
    end
    tick();
    job_valid = 1'b0;
    tests_run++;
    if ({busy, acc_rst, acc_cfg} !== {1'b1, 1'b1, cfg_b}) begin
      tests_failed++; $display("FAIL bp_accept: got b=%0b r=%0b cfg=%0h want b=1 r=1 cfg=%0h", busy, acc_rst, acc_cfg, cfg_b);
    end
    tick();
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    start_job(mk_cfg(32'd0, 32'd0, 32'd0, 32'd0, 3'b100), 16'd8);
    tick();
    in_valid = 1'b1;
    prod[0]  = 32'd9;
    tick();
    tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (acc_rst !== 1'b1) begin tests_failed++; $display("FAIL abort_acc_rst: got %0b want 1", acc_rst); end
    tick();
    rst = 1'b0;
    #1;
    clear_counts();
    tests_run++;
    if ({busy, res_valid, acc_en, job_ready} !== 4'b0001) begin
      tests_failed++; $display("FAIL abort_idle: got %b want 0001", {busy, res_valid, acc_en, job_ready});
    end
    in_valid = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    tests_run++;
    if ((resv_cnt !== 0) || (en_cnt !== 0)) begin
      tests_failed++; $display("FAIL abort_no_result: got res_valid cycles %0d acc_en cycles %0d want 0 0", resv_cnt, en_cnt);
    end
    tests_run++;
    if ((res_data !== '0) || (perf_stall !== '0)) begin
      tests_failed++; $display("FAIL abort_clear: got res %0h perf %0d want 0 0", res_data, perf_stall);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    job_valid    = 1'b0;
    job_cfg      = '0;
    job_len      = '0;
    in_valid     = 1'b0;
    res_ready    = 1'b0;
    for (int i = 0; i < 4; i++) prod[i] = '0;
    clear_counts();
    test_reset();
    test_accumulate();
    test_mult_only();
    test_stalls();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
